// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// widths, FSM state encoding and Booth recoding of the multiplier bit pair.
package mult_pkg;

    localparam int WIDTH = 32;  // operand/result width, tied to add_circuit
    localparam int CNT_W = 6;   // iteration counter, must hold WIDTH

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of {P[1], P[0]}: 01 adds M, 10 subtracts M.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_booth_seq_add_circuit.sv
// add_circuit: 32-bit two's-complement adder with carry-in and signed
// overflow flag (carry into the MSB differs from carry out of it).
module add_circuit
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_low;   // bits [30:0] sum plus carry into the MSB
    logic [1:0]       w_high;  // MSB sum plus carry out

    assign w_low      = {1'b0, i_a[WIDTH-2:0]} + {1'b0, i_b[WIDTH-2:0]}
                      + {{(WIDTH-1){1'b0}}, i_cin};
    assign w_high     = {1'b0, i_a[WIDTH-1]} + {1'b0, i_b[WIDTH-1]}
                      + {1'b0, w_low[WIDTH-1]};
    assign o_sum      = {w_high[0], w_low[WIDTH-2:0]};
    assign o_overflow = w_high[1] ^ w_low[WIDTH-1];

endmodule

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential radix-2 Booth signed multiplier, 32x32 -> low
// 32 bits plus an overflow exception. One Booth step per cycle through a
// single add_circuit; start pulse in, one-cycle ready pulse out.
module mult_booth_seq
    import mult_pkg::*;
(
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_m;          // latched multiplicand
    logic [2*WIDTH:0] r_p;          // {upper, multiplier/low, booth bit}
    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_rdy;

    booth_op_t        w_op;
    logic [WIDTH-1:0] w_add_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_upper_next;
    logic             w_msb;
    logic [2*WIDTH:0] w_p_next;
    logic             w_exc;

    // Operand B and carry-in of the shared adder come from the Booth op:
    // subtraction is A + ~M + 1.
    assign w_op    = booth_decode(r_p[1:0]);
    assign w_add_b = (w_op == BOOTH_SUB) ? ~r_m : r_m;
    assign w_cin   = (w_op == BOOTH_SUB);

    add_circuit u_add (
        .i_a        (r_p[2*WIDTH:WIDTH+1]),
        .i_b        (w_add_b),
        .i_cin      (w_cin),
        .o_sum      (w_sum),
        .o_overflow (w_ovf)
    );

    // Booth step: optional add/sub into the upper half, then arithmetic
    // shift right. The shifted-in bit is the true 33-bit sign of the sum,
    // which keeps M = 0x80000000 correct.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_upper_next = r_p[2*WIDTH:WIDTH+1];
        w_msb        = r_p[2*WIDTH];
        if (w_op != BOOTH_NOP) begin
            w_upper_next = w_sum;
            w_msb        = w_sum[WIDTH-1] ^ w_ovf;
        end
        w_p_next = {w_msb, w_upper_next, r_p[WIDTH:1]};
    end

    // Product fits in signed 32 bits only if the upper half is all copies
    // of bit 31 of the low result.
    assign w_exc = (r_p[2*WIDTH:WIDTH+1] != {WIDTH{r_p[WIDTH]}});

    // Control FSM and iteration counter; start wins over every transition.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!ctrl_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (ctrl_MULT) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Multiplicand latch and product register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_m <= '0;
            r_p <= '0;
        end else if (ctrl_MULT) begin
            r_m <= data_operandA;
            r_p <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (r_state == S_RUN) begin
            r_p <= w_p_next;
        end
    end

    // Registered outputs; the DONE cycle publishes even if a new start
    // arrives on the same edge. Results hold until the next DONE.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_result    <= r_p[WIDTH:1];
                r_exception <= w_exc;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == S_RUN) || (r_state == S_DONE);

endmodule
